hicore_hpm_csr: RTL and testbench

HICORE_HPM_CSR -- requirements
Module: hicore_hpm_csr

---
 rtl/hicore_hpm_csr.sv | 171 +++++++++++++++++
 tb/tb_hicore_hpm_csr.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hicore_hpm_csr.sv
// rtl/hicore_hpm_csr.sv - hardware performance monitor CSR block with pipelined read port
// Optional overflow flag/interrupt: define HICORE_HPM_OVF_IRQ_EN
module hicore_hpm_csr #(
    parameter int NUM_CTR = 4,
    parameter int CTR_W   = 64,
    parameter int NUM_EVT = 8,
    parameter int INFO_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic              rd_cancel,
    input  logic [11:0]       rd_idx,
    input  logic [INFO_W-1:0] rd_info,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_hit,
    output logic [31:0]       wb_rdata,
    output logic [INFO_W-1:0] wb_info,
    input  logic              commit_valid,
    input  logic              commit_wr,
    input  logic [11:0]       commit_idx,
    input  logic [31:0]       commit_data,
    input  logic              flush,
    input  logic [NUM_EVT-1:0] evt,
    output logic              ovf_irq
);
    localparam logic [11:0] ADDR_INHIBIT = 12'h320;
    localparam logic [11:0] ADDR_EVT     = 12'h323;
    localparam logic [11:0] ADDR_CTR_LO  = 12'hB03;
    localparam logic [11:0] ADDR_CTR_HI  = 12'hB83;
    localparam int          HI_W         = CTR_W - 32;

    logic [CTR_W-1:0]   ctr   [NUM_CTR];
    logic [7:0]         evsel [NUM_CTR];
    logic [NUM_CTR-1:0] inhibit;
    logic [NUM_CTR-1:0] of_q;

    logic               commit_en;
    logic               wr_inhibit;
    logic [NUM_CTR-1:0] wr_evt;
    logic [NUM_CTR-1:0] wr_lo;
    logic [NUM_CTR-1:0] wr_hi;
    logic [NUM_CTR-1:0] inc;
    logic [255:0]       evt_ext;

    logic               rd_fire;
    logic               rd_hit_c;
    logic [31:0]        rd_data_c;

    assign commit_en = commit_valid & commit_wr;
    // Selector 0 maps to the forced-zero bit 0; selectors above NUM_EVT land on zero padding.
    assign evt_ext   = 256'({evt, 1'b0});

    always_comb begin
        wr_inhibit = commit_en && (commit_idx == ADDR_INHIBIT);
        wr_evt     = '0;
        wr_lo      = '0;
        wr_hi      = '0;
        inc        = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            wr_evt[i] = commit_en && (commit_idx == ADDR_EVT + 12'(i));
            wr_lo[i]  = commit_en && (commit_idx == ADDR_CTR_LO + 12'(i));
            wr_hi[i]  = commit_en && (commit_idx == ADDR_CTR_HI + 12'(i));
            inc[i]    = evt_ext[evsel[i]] & ~inhibit[i] & ~wr_lo[i] & ~wr_hi[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inhibit <= '0;
            for (int i = 0; i < NUM_CTR; i++) begin
                ctr[i]   <= '0;
                evsel[i] <= '0;
            end
        end else begin
            if (wr_inhibit) begin
                inhibit <= commit_data[NUM_CTR+2:3];
            end
            for (int i = 0; i < NUM_CTR; i++) begin
                if (wr_evt[i]) begin
                    evsel[i] <= commit_data[7:0];
                end
                if (wr_lo[i]) begin
                    ctr[i][31:0] <= commit_data;
                end else if (wr_hi[i]) begin
                    ctr[i][CTR_W-1:32] <= commit_data[HI_W-1:0];
                end else if (inc[i]) begin
                    ctr[i] <= ctr[i] + CTR_W'(1);
                end
            end
        end
    end

`ifdef HICORE_HPM_OVF_IRQ_EN
    logic [NUM_CTR-1:0] of_next;

    // A wrap in the same cycle as a software write to OF wins, so no overflow is lost.
    always_comb begin
        of_next = of_q;
        for (int i = 0; i < NUM_CTR; i++) begin
            if (wr_evt[i]) begin
                of_next[i] = commit_data[31];
            end
            if (inc[i] && (&ctr[i])) begin
                of_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            of_q    <= '0;
            ovf_irq <= 1'b0;
        end else begin
            of_q    <= of_next;
            ovf_irq <= |of_next;
        end
    end
`else
    assign of_q    = '0;
    assign ovf_irq = 1'b0;
`endif

    always_comb begin
        rd_hit_c  = 1'b0;
        rd_data_c = '0;
        if (rd_idx == ADDR_INHIBIT) begin
            rd_hit_c  = 1'b1;
            rd_data_c = 32'({inhibit, 3'b000});
        end
        for (int i = 0; i < NUM_CTR; i++) begin
            if (rd_idx == ADDR_EVT + 12'(i)) begin
                rd_hit_c  = 1'b1;
                rd_data_c = {of_q[i], 23'd0, evsel[i]};
            end
            if (rd_idx == ADDR_CTR_LO + 12'(i)) begin
                rd_hit_c  = 1'b1;
                rd_data_c = ctr[i][31:0];
            end
            if (rd_idx == ADDR_CTR_HI + 12'(i)) begin
                rd_hit_c  = 1'b1;
                rd_data_c = 32'(ctr[i][CTR_W-1:32]);
            end
        end
    end

    assign rd_ready = ~wb_valid | wb_ready;
    assign rd_fire  = rd_valid & rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_hit   <= 1'b0;
            wb_rdata <= '0;
            wb_info  <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (rd_fire) begin
            wb_valid <= ~rd_cancel;
            if (!rd_cancel) begin
                wb_hit   <= rd_hit_c;
                wb_rdata <= rd_data_c;
                wb_info  <= rd_info;
            end
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hicore_hpm_csr.sv
// tb/tb_hicore_hpm_csr.sv - directed and randomized bench for hicore_hpm_csr against a cycle reference model
module tb_hicore_hpm_csr;
    localparam int NC = 4;
    localparam int CW = 40;
    localparam int NE = 8;
    localparam int IW = 8;
    localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;
`ifdef HICORE_HPM_OVF_IRQ_EN
    localparam bit OFEN = 1'b1;
`else
    localparam bit OFEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_valid, rd_ready, rd_cancel;
    logic [11:0] rd_idx;
    logic [IW-1:0] rd_info;
    logic wb_valid, wb_ready, wb_hit;
    logic [31:0] wb_rdata;
    logic [IW-1:0] wb_info;
    logic commit_valid, commit_wr;
    logic [11:0] commit_idx;
    logic [31:0] commit_data;
    logic flush;
    logic [NE-1:0] evt;
    logic ovf_irq;

    always #5 clk = ~clk;

    hicore_hpm_csr #(.NUM_CTR(NC), .CTR_W(CW), .NUM_EVT(NE), .INFO_W(IW)) dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_cancel(rd_cancel),
        .rd_idx(rd_idx), .rd_info(rd_info),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_hit(wb_hit),
        .wb_rdata(wb_rdata), .wb_info(wb_info),
        .commit_valid(commit_valid), .commit_wr(commit_wr), .commit_idx(commit_idx),
        .commit_data(commit_data), .flush(flush), .evt(evt), .ovf_irq(ovf_irq)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] m_ctr [NC];
    logic [7:0]  m_sel [NC];
    bit          m_inh [NC];
    bit          m_of  [NC];
    bit          m_wbv, m_hit, m_irq;
    logic [31:0] m_data;
    logic [IW-1:0] m_info;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_ctr[i] = 0; m_sel[i] = 0; m_inh[i] = 0; m_of[i] = 0;
        end
        m_wbv = 0; m_hit = 0; m_irq = 0; m_data = 0; m_info = 0;
    endtask

    function automatic void lookup(input logic [11:0] idx, output bit hit, output logic [31:0] d);
        int a;
        a = int'(idx);
        hit = 0;
        d = 0;
        if (a == 'h320) begin
            hit = 1;
            for (int i = 0; i < NC; i++) d[i+3] = m_inh[i];
        end
        for (int i = 0; i < NC; i++) begin
            if (a == 'h323 + i) begin
                hit = 1;
                d = 32'(m_sel[i]) | ((OFEN && m_of[i]) ? 32'h8000_0000 : 32'h0);
            end
            if (a == 'hB03 + i) begin hit = 1; d = m_ctr[i][31:0]; end
            if (a == 'hB83 + i) begin hit = 1; d = 32'(m_ctr[i] >> 32); end
        end
    endfunction

    task automatic tick();
        bit rdy, acc, hit, n_v, n_h, irq;
        logic [31:0] d, n_d;
        logic [IW-1:0] n_i;
        bit inc [NC];
        bit wrc [NC];
        int sel, a;
        #1;
        rdy = !m_wbv || wb_ready;
        chk("rd_ready", rd_ready, rdy);
        acc = rd_valid && rdy;
        lookup(rd_idx, hit, d);
        n_v = m_wbv; n_h = m_hit; n_d = m_data; n_i = m_info;
        if (flush) n_v = 0;
        else if (acc) begin
            n_v = !rd_cancel;
            if (!rd_cancel) begin n_h = hit; n_d = d; n_i = rd_info; end
        end else if (wb_ready) n_v = 0;
        for (int i = 0; i < NC; i++) begin
            sel = int'(m_sel[i]);
            inc[i] = !m_inh[i] && sel >= 1 && sel <= NE && evt[sel-1];
            wrc[i] = 0;
        end
        if (commit_valid && commit_wr) begin
            a = int'(commit_idx);
            if (a == 'h320) for (int i = 0; i < NC; i++) m_inh[i] = commit_data[i+3];
            for (int i = 0; i < NC; i++) begin
                if (a == 'h323 + i) begin
                    m_sel[i] = commit_data[7:0];
                    if (OFEN) m_of[i] = commit_data[31];
                end
                if (a == 'hB03 + i) begin
                    wrc[i] = 1;
                    m_ctr[i] = (m_ctr[i] & ~64'hFFFF_FFFF) | 64'(commit_data);
                end
                if (a == 'hB83 + i) begin
                    wrc[i] = 1;
                    m_ctr[i] = ((m_ctr[i] & 64'hFFFF_FFFF) | (64'(commit_data) << 32)) & MASK;
                end
            end
        end
        irq = 0;
        for (int i = 0; i < NC; i++) begin
            if (inc[i] && !wrc[i]) begin
                m_ctr[i] = (m_ctr[i] + 64'd1) & MASK;
                if (m_ctr[i] == 0 && OFEN) m_of[i] = 1;
            end
            irq = irq || (OFEN && m_of[i]);
        end
        @(posedge clk);
        #1;
        m_wbv = n_v; m_hit = n_h; m_data = n_d; m_info = n_i; m_irq = irq;
        chk("wb_valid", wb_valid, m_wbv);
        if (m_wbv) begin
            chk("wb_hit", wb_hit, m_hit);
            chk("wb_rdata", wb_rdata, m_data);
            chk("wb_info", wb_info, m_info);
        end
        chk("ovf_irq", ovf_irq, m_irq);
    endtask

    task automatic idle();
        rd_valid = 0; rd_cancel = 0; rd_idx = 0; rd_info = 0; wb_ready = 1;
        commit_valid = 0; commit_wr = 0; commit_idx = 0; commit_data = 0; flush = 0;
    endtask

    task automatic commit(input logic [11:0] idx, input logic [31:0] data);
        commit_valid = 1; commit_wr = 1; commit_idx = idx; commit_data = data;
        tick();
        commit_valid = 0; commit_wr = 0;
    endtask

    task automatic read(input logic [11:0] idx);
        rd_valid = 1; rd_idx = idx; rd_info = IW'($urandom);
        tick();
        rd_valid = 0;
    endtask

    function automatic logic [11:0] pick_idx();
        logic [11:0] k;
        k = 12'($urandom_range(0, NC - 1));
        case ($urandom_range(0, 7))
            0: return 12'h320;
            1: return 12'h323 + k;
            2: return 12'hB03 + k;
            3: return 12'hB83 + k;
            4: return 12'hB1F;
            5: return 12'h327;
            6: return 12'hB87;
            default: return 12'($urandom);
        endcase
    endfunction

    initial begin
        idle();
        evt = 0;
        model_reset();
        #3;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_hit", wb_hit, 0);
        chk("rst_wb_rdata", wb_rdata, 0);
        chk("rst_wb_info", wb_info, 0);
        chk("rst_ovf_irq", ovf_irq, 0);
        @(posedge clk);
        #1;
        rst = 0;

        commit(12'h323, 32'd1);
        evt = 1;
        repeat (10) tick();
        evt = 0;
        read(12'hB03);
        chk("cnt10_valid", wb_valid, 1);
        chk("cnt10_hit", wb_hit, 1);
        chk("cnt10_rdata", wb_rdata, 10);

        commit(12'h320, 32'h8);
        evt = 1;
        repeat (5) tick();
        read(12'hB03);
        chk("inhibit_hold", wb_rdata, 10);
        commit(12'h320, 32'h0);
        tick();
        read(12'hB03);
        chk("inhibit_resume", wb_rdata, 11);
        evt = 0;

        commit(12'hB03, 32'hFFFF_FFFF);
        evt = 1;
        tick();
        evt = 0;
        read(12'hB03);
        chk("carry_lo", wb_rdata, 0);
        read(12'hB83);
        chk("carry_hi", wb_rdata, 1);
        evt = 1;
        commit(12'hB03, 32'h1234_5678);
        evt = 0;
        read(12'hB03);
        chk("wr_prio_lo", wb_rdata, 32'h1234_5678);
        read(12'hB83);
        chk("wr_prio_hi", wb_rdata, 1);

        commit(12'hB83, 32'hFF);
        commit(12'hB03, 32'hFFFF_FFFF);
        evt = 1;
        tick();
        evt = 0;
        chk("wrap_irq", ovf_irq, OFEN);
        read(12'hB03);
        chk("wrap_lo", wb_rdata, 0);
        read(12'hB83);
        chk("wrap_hi", wb_rdata, 0);
        read(12'h323);
        chk("wrap_of", wb_rdata, OFEN ? 32'h8000_0001 : 32'h1);
        commit(12'h323, 32'h1);
        chk("of_clear_irq", ovf_irq, 0);

        read(12'hB1F);
        chk("unimpl_valid", wb_valid, 1);
        chk("unimpl_hit", wb_hit, 0);
        chk("unimpl_rdata", wb_rdata, 0);
        wb_ready = 0; rd_valid = 1; rd_idx = 12'hB03;
        repeat (3) begin
            tick();
            chk("stall_rd_ready", rd_ready, 0);
            chk("stall_valid", wb_valid, 1);
            chk("stall_hit", wb_hit, 0);
            chk("stall_rdata", wb_rdata, 0);
        end
        wb_ready = 1;
        tick();
        flush = 1;
        tick();
        chk("flush_valid", wb_valid, 0);
        idle();

        rd_valid = 1; rd_idx = 12'hB03;
        tick();
        wb_ready = 0; rd_valid = 0;
        #2;
        rst = 1;
        #1;
        chk("midrst_valid", wb_valid, 0);
        chk("midrst_rdata", wb_rdata, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        wb_ready = 1;
        tick();
        chk("midrst_no_replay", wb_valid, 0);
        read(12'hB03);
        chk("midrst_ctr_clr", wb_rdata, 0);

        for (int c = 0; c < 600; c++) begin
            rd_valid = ($urandom_range(0, 99) < 60);
            rd_cancel = ($urandom_range(0, 99) < 10);
            rd_idx = pick_idx();
            rd_info = IW'($urandom);
            wb_ready = ($urandom_range(0, 99) < 75);
            flush = ($urandom_range(0, 99) < 5);
            evt = NE'($urandom);
            commit_valid = ($urandom_range(0, 99) < 35);
            commit_wr = ($urandom_range(0, 99) < 80);
            commit_idx = pick_idx();
            commit_data = $urandom;
            if (commit_idx >= 12'h323 && commit_idx < 12'h323 + 12'(NC))
                commit_data[7:0] = 8'($urandom_range(0, 10));
            else if (commit_idx >= 12'hB83 && commit_idx < 12'hB83 + 12'(NC))
                commit_data = $urandom_range(0, 1) ? 32'hFF : $urandom;
            else if (commit_idx >= 12'hB03 && commit_idx < 12'hB03 + 12'(NC))
                commit_data = $urandom_range(0, 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            tick();
        end
        idle();
        evt = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
